// File: rtl/map_lfsr_gen.sv
// ----------------------------------------------------------------------------
// map_lfsr_gen
//   Start-triggered LFSR shifter. A rising edge on the (asynchronous) start
//   input loads N into a down-counter and a seed into a Fibonacci LFSR, shifts
//   the LFSR N times, then captures {sr, ^sr} into dp and raises done.
//   In continuous mode the block re-loads the counter after every capture and
//   keeps shifting the same LFSR, so successive results form one chained
//   sequence.
//
// Parameters
//   CW    counter / N width in bits (2..16)
//   SW    LFSR width in bits (4..32)
//   TAPS  SW-bit feedback tap mask
//
// Ports
//   clock    in   single rising-edge clock
//   reset    in   asynchronous active-low reset
//   start    in   asynchronous run request, acted on at its rising edge
//   mode     in   0 = single-shot, 1 = continuous (sampled only at capture)
//   N        in   shift count per run (sampled only in LOAD)
//   seed     in   LFSR seed for the first run (sampled only in LOAD)
//   done     out  registered result-valid flag
//   busy     out  high whenever the FSM is not idle
//   counter  out  remaining shift count
//   sr       out  LFSR contents
//   dp       out  captured result {sr, ^sr}
// ----------------------------------------------------------------------------
module map_lfsr_gen #(
  parameter int unsigned      CW   = 8,
  parameter int unsigned      SW   = 8,
  parameter logic [SW-1:0]    TAPS = 8'hB8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [CW-1:0] N,
  input  logic [SW-1:0] seed,
  output logic          done,
  output logic          busy,
  output logic [CW-1:0] counter,
  output logic [SW-1:0] sr,
  output logic [SW:0]   dp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;
  localparam logic [1:0] CAPTURE = 2'd3;

  localparam logic [SW-1:0] ONES = '1;

  logic [1:0] state;
  logic       sb0;
  logic       sb1;
  logic       start_edge;
  logic       chain;      // set when LOAD is a continuous re-entry

  // NOTE: the synchroniser resets to 1, not 0, so a start input already held
  // high when reset releases is seen as a steady level rather than a new edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb0 <= 1'b1;
      sb1 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make sb1 take the old sb0, giving a
      // two-stage pipeline; blocking here would collapse it to one flop.
      sb0 <= start;
      sb1 <= sb0;
    end
  end

  assign start_edge = sb0 & ~sb1;
  assign busy       = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      sr      <= '0;
      dp      <= '0;
      done    <= 1'b0;
      chain   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Start edges are only honoured here; in any other state they are
          // dropped, never queued.
          if (start_edge) state <= LOAD;
        end

        LOAD: begin
          counter <= N;
          if (!chain) begin
            // An all-zero LFSR would never leave zero, so substitute all-ones.
            sr <= (seed == '0) ? ONES : seed;
          end else if (sr == '0) begin
            sr <= ONES;
          end
          done  <= 1'b0;
          state <= RUN;
        end

        RUN: begin
          if (counter != '0) begin
            sr      <= {sr[SW-2:0], ^(sr & TAPS)};
            counter <= counter - 1'b1;
          end else begin
            // Counter stops at zero; the capture happens on the next edge.
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          dp   <= {sr, ^sr};
          done <= 1'b1;
          if (mode) begin
            chain <= 1'b1;
            state <= LOAD;
          end else begin
            chain <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_map_lfsr_gen.sv
// ----------------------------------------------------------------------------
// tb_map_lfsr_gen
//   Directed bench for map_lfsr_gen (CW=8, SW=8, TAPS=8'hB8). Each run pushes
//   its expected dp and the cycle at which done must rise into a scoreboard;
//   a monitor pops an entry on every rising edge of done and compares.
//   Stimulus also checks reset values, the shift sequence, the busy/done
//   levels and the counter behaviour directly.
// ----------------------------------------------------------------------------
module tb_map_lfsr_gen;

  logic       clock;
  logic       reset;
  logic       start;
  logic       mode;
  logic [7:0] n_in;
  logic [7:0] seed;
  logic       done;
  logic       busy;
  logic [7:0] counter;
  logic [7:0] sr;
  logic [8:0] dp;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  typedef struct {
    logic [8:0] dp;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sbq[$];

  map_lfsr_gen #(.CW(8), .SW(8), .TAPS(8'hB8)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .N       (n_in),
    .seed    (seed),
    .done    (done),
    .busy    (busy),
    .counter (counter),
    .sr      (sr),
    .dp      (dp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // cyc holds the index of the most recent rising edge.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] lfsr_model(input logic [7:0] s0, input int n);
    logic [7:0] s;
    s = (s0 == 8'h00) ? 8'hFF : s0;
    for (int i = 0; i < n; i++) s = {s[6:0], ^(s & 8'hB8)};
    return {s, ^s};
  endfunction

  // Scoreboard monitor: compares on each rising edge of done.
  logic done_prev = 1'b0;
  always @(negedge clock) begin
    if (done && !done_prev) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_done: done rose at cycle %0d, no result expected", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_dp"}, 32'(dp), 32'(e.dp));
        check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
    done_prev = done;
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clock);
  endtask

  // Issues one start pulse; k returns the edge at which sb0 first samples 1.
  // On return the bench sits at the falling edge just after edge k.
  task automatic start_run(input logic [7:0] s, input logic [7:0] n,
                           input logic m, input logic keep_high, output int k);
    @(negedge clock);
    start = 1'b0;
    seed  = s;
    n_in  = n;
    mode  = m;
    @(negedge clock);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    if (!keep_high) start = 1'b0;
  endtask

  initial begin
    int         k;
    logic [7:0] seq [5];
    logic [7:0] prev;
    int         decs;
    int         zeros;

    reset = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    n_in  = 8'h00;
    seed  = 8'h00;
    #1;
    check("reset_done",    32'(done),    32'h0);
    check("reset_busy",    32'(busy),    32'h0);
    check("reset_counter", 32'(counter), 32'h0);
    check("reset_sr",      32'(sr),      32'h0);
    check("reset_dp",      32'(dp),      32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Single-shot, seed 01, N 4.
    seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    start_run(8'h01, 8'd4, 1'b0, 1'b0, k);
    sbq.push_back('{dp: 9'h022, cyc: k + 8, name: "single_n4"});
    wait_cyc(k + 1);
    check("single_busy_load", 32'(busy), 32'h1);
    for (int i = 0; i < 5; i++) begin
      wait_cyc(k + 2 + i);
      check($sformatf("single_sr_step%0d", i), 32'(sr), 32'(seq[i]));
    end
    wait_cyc(k + 9);
    check("single_busy_after", 32'(busy), 32'h0);
    check("single_done_held",  32'(done), 32'h1);

    // Zero seed guard, N 0.
    start_run(8'h00, 8'd0, 1'b0, 1'b0, k);
    sbq.push_back('{dp: 9'h1FE, cyc: k + 4, name: "zero_seed"});
    wait_cyc(k + 2);
    check("zero_seed_sr", 32'(sr), 32'hFF);
    wait_cyc(k + 6);

    // Continuous, seed 01, N 2; mode cleared before the second capture.
    start_run(8'h01, 8'd2, 1'b1, 1'b0, k);
    sbq.push_back('{dp: 9'h009, cyc: k + 6,  name: "cont_first"});
    sbq.push_back('{dp: 9'h022, cyc: k + 11, name: "cont_second"});
    wait_cyc(k + 7);
    check("cont_done_pulse_low", 32'(done), 32'h0);
    check("cont_busy_reload",    32'(busy), 32'h1);
    mode = 1'b0;
    wait_cyc(k + 12);
    check("cont_busy_stop",  32'(busy), 32'h0);
    check("cont_done_held",  32'(done), 32'h1);
    wait_cyc(k + 15);
    check("cont_stays_idle", 32'(busy), 32'h0);

    // Extra start pulse during RUN is ignored.
    start_run(8'h01, 8'd10, 1'b0, 1'b0, k);
    sbq.push_back('{dp: 9'h0E2, cyc: k + 14, name: "extra_start"});
    wait_cyc(k + 5);
    start = 1'b1;
    wait_cyc(k + 7);
    start = 1'b0;
    wait_cyc(k + 22);
    check("extra_start_idle", 32'(busy), 32'h0);

    // Reset mid-run with start held high across release.
    start_run(8'h01, 8'd6, 1'b0, 1'b1, k);
    wait_cyc(k + 5);
    check("abort_counter_before", 32'(counter), 32'h3);
    check("abort_busy_before",    32'(busy),    32'h1);
    reset = 1'b0;
    #1;
    check("abort_done",    32'(done),    32'h0);
    check("abort_busy",    32'(busy),    32'h0);
    check("abort_counter", 32'(counter), 32'h0);
    check("abort_sr",      32'(sr),      32'h0);
    check("abort_dp",      32'(dp),      32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    check("abort_no_restart_busy", 32'(busy), 32'h0);
    check("abort_no_restart_sr",   32'(sr),   32'h0);
    start_run(8'h01, 8'd1, 1'b0, 1'b0, k);
    sbq.push_back('{dp: 9'h005, cyc: k + 5, name: "after_abort"});
    wait_cyc(k + 7);

    // N = 255: counter walks down once with no wrap.
    start_run(8'h01, 8'hFF, 1'b0, 1'b0, k);
    sbq.push_back('{dp: lfsr_model(8'h01, 255), cyc: k + 4 + 255, name: "n255"});
    wait_cyc(k + 2);
    check("n255_counter_load", 32'(counter), 32'hFF);
    prev  = counter;
    decs  = 0;
    zeros = 0;
    while (cyc < k + 4 + 255) begin
      @(negedge clock);
      if (counter == 8'(prev - 8'd1)) decs++;
      if (prev != 8'h00 && counter == 8'h00) zeros++;
      prev = counter;
    end
    check("n255_decrements",  32'(decs),    32'd255);
    check("n255_zero_once",   32'(zeros),   32'd1);
    check("n255_counter_end", 32'(counter), 32'h0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clock);
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_checks++;
      n_fails++;
      $display("FAIL %s_missing: done never rose, expected dp 0x%0h at cycle %0d",
               e.name, e.dp, e.cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Absolute guard against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
